// File: rtl/fp_interp_pipe.sv
// Three-stage pipelined fixed-point interpolator y = m*x + b with valid/ready flow control.
// Define FP_INTERP_PIPE_SAT_EN to saturate on overflow; otherwise out_y wraps.
module fp_interp_pipe #(
  parameter int IW_M   = 4,
  parameter int QW_M   = 12,
  parameter int IW_X   = 6,
  parameter int QW_X   = 10,
  parameter int IW_B   = 8,
  parameter int QW_B   = 10,
  parameter int IW_Y   = 8,
  parameter int QW_Y   = 14,
  parameter int NUM_CH = 4,
  parameter int ROUND  = 0,
  localparam int CHW   = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IW_M+QW_M-1:0]   in_m,
  input  logic [IW_X+QW_X-1:0]   in_x,
  input  logic [IW_B+QW_B-1:0]   in_b,
  input  logic [CHW-1:0]         in_ch,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IW_Y+QW_Y-1:0]   out_y,
  output logic [CHW-1:0]         out_ch,
  output logic                   out_ovf,
  output logic [NUM_CH-1:0]      ovf_flags,
  input  logic [NUM_CH-1:0]      ovf_clr
);
  localparam int STAGES = 3;
  localparam int MW   = IW_M + QW_M;
  localparam int XW   = IW_X + QW_X;
  localparam int BW   = IW_B + QW_B;
  localparam int YW   = IW_Y + QW_Y;
  localparam int PW   = MW + XW;
  localparam int QW_P = QW_M + QW_X;
  localparam int IW_S = (((IW_M + IW_X) > IW_B) ? (IW_M + IW_X) : IW_B) + 1;
  localparam int QW_S = (QW_P > QW_B) ? QW_P : QW_B;
  localparam int SW   = IW_S + QW_S;
  localparam int QN   = (QW_S > QW_Y) ? (SW + 1 - (QW_S - QW_Y)) : (SW + QW_Y - QW_S);

  logic [STAGES:1]       vld_pipe;
  logic                  en1, en2, en3;
  logic signed [PW-1:0]  p1;
  logic signed [BW-1:0]  b1;
  logic [CHW-1:0]        ch1, ch2;
  logic signed [SW-1:0]  pa, ba, s2;
  logic signed [QN-1:0]  q;
  logic [YW-1:0]         yq;
  logic                  ovq;

  // A stage may load when empty or when its occupant moves on this cycle.
  assign en3       = !vld_pipe[3] || out_ready;
  assign en2       = !vld_pipe[2] || en3;
  assign en1       = !vld_pipe[1] || en2;
  assign in_ready  = en1;
  assign out_valid = vld_pipe[3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (en1) vld_pipe[1] <= in_valid;
      if (en2) vld_pipe[2] <= vld_pipe[1];
      if (en3) vld_pipe[3] <= vld_pipe[2];
    end
  end

  assign pa = SW'(p1) <<< (QW_S - QW_P);
  assign ba = SW'(b1) <<< (QW_S - QW_B);

  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      p1  <= PW'($signed(in_m)) * PW'($signed(in_x));
      b1  <= in_b;
      ch1 <= in_ch;
    end
    if (en2 && vld_pipe[1]) begin
      s2  <= pa + ba;
      ch2 <= ch1;
    end
  end

  generate
    if (QW_S > QW_Y) begin : g_rnd
      localparam int DSH = QW_S - QW_Y;
      localparam logic [SW:0] HALF = (ROUND != 0) ? ({{SW{1'b0}}, 1'b1} << (DSH - 1)) : '0;
      logic [SW:0] rsum;
      logic        unused_lsb;
      // One guard bit so the rounding increment can never wrap.
      assign rsum       = {s2[SW-1], s2} + HALF;
      assign q          = $signed(rsum[SW:DSH]);
      assign unused_lsb = ^rsum[DSH-1:0];
    end else begin : g_pad
      assign q = QN'(s2) <<< (QW_Y - QW_S);
    end

    if (QN > YW) begin : g_fit
      logic [QN-YW:0] top;
      assign top = q[QN-1:YW-1];
      assign ovq = !((&top) || (~|top));
`ifdef FP_INTERP_PIPE_SAT_EN
      assign yq = !ovq ? q[YW-1:0] :
                  q[QN-1] ? {1'b1, {(YW-1){1'b0}}} : {1'b0, {(YW-1){1'b1}}};
`else
      assign yq = q[YW-1:0];
`endif
    end else begin : g_ext
      assign yq  = YW'(q);
      assign ovq = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_y   <= '0;
      out_ch  <= '0;
      out_ovf <= 1'b0;
    end else if (en3 && vld_pipe[2]) begin
      out_y   <= yq;
      out_ch  <= ch2;
      out_ovf <= ovq;
    end
  end

  // Set takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_flags <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (out_valid && out_ready && out_ovf && (out_ch == CHW'(i)))
          ovf_flags[i] <= 1'b1;
        else if (ovf_clr[i])
          ovf_flags[i] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp_interp_pipe.sv
// Scoreboard bench for fp_interp_pipe: default build plus two QW_Y=8 builds (round / floor) in lockstep.
module tb_fp_interp_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, out_ready;
  logic [15:0] in_m, in_x;
  logic [17:0] in_b;
  logic [1:0]  in_ch;
  logic [3:0]  ovf_clr;

  logic        in_ready, out_valid, out_ovf;
  logic [21:0] out_y;
  logic [1:0]  out_ch;
  logic [3:0]  ovf_flags;
  logic        r_in_ready, r_out_valid, r_out_ovf;
  logic [15:0] r_out_y;
  logic [1:0]  r_out_ch;
  logic [3:0]  r_ovf_flags;
  logic        f_in_ready, f_out_valid, f_out_ovf;
  logic [15:0] f_out_y;
  logic [1:0]  f_out_ch;
  logic [3:0]  f_ovf_flags;

  fp_interp_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_m(in_m), .in_x(in_x), .in_b(in_b), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_ch(out_ch),
    .out_ovf(out_ovf), .ovf_flags(ovf_flags), .ovf_clr(ovf_clr));

  fp_interp_pipe #(.QW_Y(8), .ROUND(1)) u_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready),
    .in_m(in_m), .in_x(in_x), .in_b(in_b), .in_ch(in_ch),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_y(r_out_y), .out_ch(r_out_ch),
    .out_ovf(r_out_ovf), .ovf_flags(r_ovf_flags), .ovf_clr(ovf_clr));

  fp_interp_pipe #(.QW_Y(8), .ROUND(0)) u_f (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(f_in_ready),
    .in_m(in_m), .in_x(in_x), .in_b(in_b), .in_ch(in_ch),
    .out_valid(f_out_valid), .out_ready(out_ready), .out_y(f_out_y), .out_ch(f_out_ch),
    .out_ovf(f_out_ovf), .ovf_flags(f_ovf_flags), .ovf_clr(ovf_clr));

  typedef struct {
    longint     y0, y1, y2;
    bit         o0, o1, o2;
    logic [1:0] ch;
  } exp_t;

  exp_t       sb[$];
  int         total = 0, bad = 0, n_in = 0, n_out = 0;
  logic [3:0] mflags = '0;
  bit         mon_en = 0, rnd_rdy = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Exact real value in units of 2^-22, quantised to qwy fractional bits, 8 integer bits.
  function automatic void ref_y(input logic [15:0] m, x, input logic [17:0] b,
                                input int qwy, input bit rnd, output longint y, output bit ovf);
    longint v, q, lo, hi;
    int sh, w;
    v  = longint'($signed(m)) * longint'($signed(x)) + longint'($signed(b)) * 4096;
    sh = 22 - qwy;
    w  = 8 + qwy;
    if (rnd) v = v + (longint'(1) <<< (sh - 1));
    q   = v >>> sh;
    lo  = -(longint'(1) <<< (w - 1));
    hi  = -lo - 1;
    ovf = (q < lo) || (q > hi);
`ifdef FP_INTERP_PIPE_SAT_EN
    y = !ovf ? q : (q < 0) ? lo : hi;
`else
    y = (q <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] nf;
    if (mon_en) begin
      if (!rst_n) begin
        sb.delete();
        mflags = '0;
      end else begin
        chk("ovf_flags", ovf_flags, mflags);
        chk("lockstep", {r_out_valid, f_out_valid, r_in_ready, f_in_ready},
                        {out_valid, out_valid, in_ready, in_ready});
        nf = mflags & ~ovf_clr;
        if (in_valid && in_ready) begin
          ref_y(in_m, in_x, in_b, 14, 1'b0, e.y0, e.o0);
          ref_y(in_m, in_x, in_b, 8, 1'b1, e.y1, e.o1);
          ref_y(in_m, in_x, in_b, 8, 1'b0, e.y2, e.o2);
          e.ch = in_ch;
          sb.push_back(e);
          n_in++;
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (sb.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("out_ch", out_ch, e.ch);
            chk("out_y", $signed(out_y), e.y0);
            chk("out_ovf", out_ovf, e.o0);
            chk("r_out_y", $signed(r_out_y), e.y1);
            chk("r_out_ovf", r_out_ovf, e.o1);
            chk("f_out_y", $signed(f_out_y), e.y2);
            chk("f_out_ovf", f_out_ovf, e.o2);
            if (e.o0) nf[e.ch] = 1'b1;
          end
        end
        mflags = nf;
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
      ovf_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
    end
  end

  task automatic send();
    bit ok = 0;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive(input logic [15:0] m, x, input logic [17:0] b, input logic [1:0] ch);
    in_m = m; in_x = x; in_b = b; in_ch = ch;
    send();
  endtask

  task automatic rand_in(input int k);
    logic signed [15:0] t;
    t = 16'($urandom); in_m = t >>> $urandom_range(0, 8);
    t = 16'($urandom); in_x = t >>> $urandom_range(0, 8);
    in_b  = 18'($urandom);
    in_ch = 2'(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx, base_out, guard;
    bit acc;
    logic [21:0] held;
    rst_n = 0; in_valid = 0; out_ready = 1; ovf_clr = 0;
    in_m = 0; in_x = 0; in_b = 0; in_ch = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ovf_flags", ovf_flags, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_ovf", out_ovf, 0);
    mon_en = 1;

    drive(16'h1800, 16'h1000, 18'h00C80, 2'd2);
    @(posedge clk); #1 chk("lat_early", out_valid, 0);
    @(posedge clk); #1;
    chk("basic_valid", out_valid, 1);
    chk("basic_y", $signed(out_y), 149504);
    chk("basic_ch", out_ch, 2);
    chk("basic_ovf", out_ovf, 0);
    repeat (2) @(posedge clk); #1;

    drive(16'h7000, 16'h7C00, 18'h0, 2'd1);
    repeat (2) @(posedge clk); #1;
`ifdef FP_INTERP_PIPE_SAT_EN
    chk("ovf_y", $signed(out_y), 2097151);
`else
    chk("ovf_y", $signed(out_y), -638976);
`endif
    chk("ovf_bit", out_ovf, 1);
    @(posedge clk); #1 chk("ovf_flags_set", ovf_flags, 4'b0010);
    ovf_clr = 4'b0010;
    @(posedge clk); #1 ovf_clr = 4'b0000;
    chk("ovf_flags_clr", ovf_flags, 0);

    drive(16'h0008, 16'h0400, 18'h0, 2'd0);
    repeat (2) @(posedge clk); #1;
    chk("round_pos", $signed(r_out_y), 1);
    chk("floor_pos", $signed(f_out_y), 0);
    drive(16'hFFF8, 16'h0400, 18'h0, 2'd3);
    repeat (2) @(posedge clk); #1;
    chk("round_neg", $signed(r_out_y), 0);
    chk("floor_neg", $signed(f_out_y), -1);
    repeat (3) @(posedge clk); #1;

    // Backpressure: five beats offered against a stalled sink.
    out_ready = 0; base_out = n_out; idx = 0;
    rand_in(idx); in_valid = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; rand_in(idx); end
    end
    chk("bp_accepted", idx, 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    held = out_y;
    repeat (3) @(posedge clk); #1;
    chk("bp_hold", out_y, held);
    out_ready = 1; guard = 0;
    while (idx < 5 && guard < 50) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; if (idx < 5) rand_in(idx); end
      guard++;
    end
    in_valid = 0;
    chk("bp_all_in", idx, 5);
    guard = 0;
    while (n_out - base_out < 5 && guard < 50) begin @(posedge clk); #1; guard++; end
    repeat (3) @(posedge clk); #1;
    chk("bp_results", n_out - base_out, 5);

    rnd_rdy = 1;
    for (int k = 0; k < 1000; k++) begin
      rand_in(k);
      send();
      @(posedge clk); #1;
    end
    rnd_rdy = 0;
    @(posedge clk); #2;
    out_ready = 1; ovf_clr = 0;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("drain", sb.size(), 0);

    drive(16'h7000, 16'h7C00, 18'h0, 2'd3);
    repeat (4) @(posedge clk); #1;
    chk("pre_rst_flag3", ovf_flags[3], 1);
    rand_in(0); send();
    rand_in(1); send();
    rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_ovf_flags", ovf_flags, 0);
    chk("rst2_in_ready", in_ready, 1);
    base_out = n_out;
    repeat (8) @(posedge clk); #1;
    chk("no_stale", n_out - base_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
